pc_pipe_buffer: RTL

//  Parametrised successor to the single-stage 8-bit PC register. Carries the fetch PC down a

---
 rtl/pc_pipe_buffer.sv | 68 ++++++
 1 files changed

// File: rtl/pc_pipe_buffer.sv
// DEPTH-stage PC delay line with per-stage valid bits, global stall, bubble-inserting
// flush and a registered occupancy count. Sits between fetch and decode/execute.
module pc_pipe_buffer #(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 3,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           pc_in,
    input  logic                       valid_in,
    input  logic                       stall,
    input  logic                       flush,
    output logic [WIDTH-1:0]           pc_out,
    output logic                       valid_out,
    output logic [WIDTH*DEPTH-1:0]     pc_taps,
    output logic [DEPTH-1:0]           valid_taps,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] pc_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [OW-1:0]    occ_q;
    logic [OW-1:0]    occ_next;

    // One entry enters at stage 0 and one leaves from the last stage on every advance.
    always_comb begin
        occ_next = occ_q + OW'(valid_in) - OW'(valid_q[DEPTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                pc_q[k] <= RESET_PC;
            end
            valid_q <= '0;
            occ_q   <= '0;
        end else if (flush) begin
            // PCs keep moving for debug visibility; only the valid bits are killed.
            pc_q[0] <= pc_in;
            for (int k = 1; k < DEPTH; k++) begin
                pc_q[k] <= pc_q[k-1];
            end
            valid_q <= '0;
            occ_q   <= '0;
        end else if (!stall) begin
            pc_q[0]    <= pc_in;
            valid_q[0] <= valid_in;
            for (int k = 1; k < DEPTH; k++) begin
                pc_q[k]    <= pc_q[k-1];
                valid_q[k] <= valid_q[k-1];
            end
            occ_q <= occ_next;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_taps
        assign pc_taps[g*WIDTH +: WIDTH] = pc_q[g];
    end

    assign valid_taps = valid_q;
    assign pc_out     = pc_q[DEPTH-1];
    assign valid_out  = valid_q[DEPTH-1];
    assign occupancy  = occ_q;

endmodule
